// File: rtl/uart_parity_unit_if.sv
// rtl/uart_parity_unit_if.sv - input/output beat streams of the parity unit
// The master side drives input beats and accepts output beats.
interface uart_parity_unit_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_par;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_par, out_ready,
        input  in_ready, out_valid, out_data, out_par, out_err
    );

    modport slave (
        input  in_valid, in_data, in_par, out_ready,
        output in_ready, out_valid, out_data, out_par, out_err
    );
endinterface

// File: rtl/uart_parity_unit.sv
// rtl/uart_parity_unit.sv - UART parity generator/checker with one registered output stage
// Configuration is taken with each accepted beat, so modes may change on any beat boundary.
module uart_parity_unit #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             parity_en,
    input  logic [1:0]       par_mode,
    input  logic [3:0]       char_len,
    input  logic             chk_mode,
    uart_parity_unit_if.slave bus,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_cnt_clr
);
    localparam logic [4:0] MAX_LEN = 5'(DATA_W);
    localparam logic [4:0] MIN_LEN = 5'd5;

    localparam logic [1:0] MODE_EVEN  = 2'b00;
    localparam logic [1:0] MODE_ODD   = 2'b01;
    localparam logic [1:0] MODE_MARK  = 2'b10;
    localparam logic [1:0] MODE_SPACE = 2'b11;

    logic [4:0]        eff_len;
    logic [DATA_W-1:0] len_mask;
    logic [DATA_W-1:0] masked_data;
    logic              data_xor;
    logic              par_bit;
    logic              par_err;
    logic              accept;
    logic              cnt_full;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_par_q;
    logic              out_err_q;

    // Out-of-range lengths clamp to the nearest legal width instead of being rejected.
    always_comb begin
        eff_len = {1'b0, char_len};
        if ({1'b0, char_len} < MIN_LEN) begin
            eff_len = MIN_LEN;
        end else if ({1'b0, char_len} > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            len_mask[i] = (5'(i) < eff_len);
        end
    end

    assign masked_data = bus.in_data & len_mask;
    assign data_xor    = ^masked_data;

    always_comb begin
        par_bit = 1'b0;
        if (parity_en) begin
            case (par_mode)
                MODE_EVEN:  par_bit = data_xor;
                MODE_ODD:   par_bit = ~data_xor;
                MODE_MARK:  par_bit = 1'b1;
                MODE_SPACE: par_bit = 1'b0;
                default:    par_bit = 1'b0;
            endcase
        end
    end

    assign par_err  = parity_en && chk_mode && (bus.in_par != par_bit);
    assign cnt_full = (err_cnt == {CNT_W{1'b1}});

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Payload only moves on accept, which keeps it stable while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_par_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else if (accept) begin
            out_data_q <= masked_data;
            out_par_q  <= par_bit;
            out_err_q  <= par_err;
        end
    end

    // Clear wins over a same-cycle increment so software sees a clean zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (accept && par_err && !cnt_full) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_par   = out_par_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_uart_parity_unit.sv
// tb/tb_uart_parity_unit.sv - directed self-checking bench for uart_parity_unit
// DUT uses DATA_W=8, CNT_W=2 so counter saturation is reachable quickly.
module tb_uart_parity_unit;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             parity_en = 1'b1;
    logic [1:0]       par_mode = 2'b00;
    logic [3:0]       char_len = 4'd8;
    logic             chk_mode = 1'b0;
    logic             err_cnt_clr = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    uart_parity_unit_if #(.DATA_W(DATA_W)) bus ();

    uart_parity_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .parity_en   (parity_en),
        .par_mode    (par_mode),
        .char_len    (char_len),
        .chk_mode    (chk_mode),
        .bus         (bus),
        .err_cnt     (err_cnt),
        .err_cnt_clr (err_cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] d, input logic p);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_par   = p;
        for (int k = 0; k < 20; k++) begin
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout data=%h in_ready=%b required=1", d, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_par = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        checks++;
        if (err_cnt !== 2'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_even_gen;
        parity_en = 1; par_mode = 2'b00; chk_mode = 0; char_len = 4'd8;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL even_pre_valid got=%b exp=0", bus.out_valid); end
        send(8'hA5, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL even_latency got=%b exp=1", bus.out_valid); end
        checks++;
        if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL even_data got=%h exp=a5", bus.out_data); end
        checks++;
        if (bus.out_par !== 1'b0) begin errors++; $display("FAIL even_par got=%b exp=0", bus.out_par); end
        checks++;
        if (bus.out_err !== 1'b0) begin errors++; $display("FAIL even_err got=%b exp=0", bus.out_err); end
        // length above DATA_W clamps to 8: 8'hF1 has five ones
        char_len = 4'd12;
        send(8'hF1, 1'b0);
        checks++;
        if (bus.out_data !== 8'hF1 || bus.out_par !== 1'b1) begin
            errors++; $display("FAIL even_len12 got=%h/%b exp=f1/1", bus.out_data, bus.out_par);
        end
    endtask

    task automatic test_odd_len;
        parity_en = 1; par_mode = 2'b01; chk_mode = 0; char_len = 4'd7;
        send(8'hFF, 1'b0);
        checks++;
        if (bus.out_data !== 8'h7F || bus.out_par !== 1'b0) begin
            errors++; $display("FAIL odd_len7 got=%h/%b exp=7f/0", bus.out_data, bus.out_par);
        end
        char_len = 4'd3;
        send(8'hFF, 1'b0);
        checks++;
        if (bus.out_data !== 8'h1F || bus.out_par !== 1'b0) begin
            errors++; $display("FAIL odd_len3 got=%h/%b exp=1f/0", bus.out_data, bus.out_par);
        end
        char_len = 4'd6;
        send(8'hC3, 1'b0);
        checks++;
        if (bus.out_data !== 8'h03 || bus.out_par !== 1'b1) begin
            errors++; $display("FAIL odd_len6 got=%h/%b exp=03/1", bus.out_data, bus.out_par);
        end
    endtask

    task automatic test_check_mode;
        parity_en = 1; par_mode = 2'b00; chk_mode = 1; char_len = 4'd8;
        send(8'h01, 1'b0);
        checks++;
        if (bus.out_err !== 1'b1 || bus.out_par !== 1'b1) begin
            errors++; $display("FAIL chk_even_bad got=%b/%b exp=err1/par1", bus.out_err, bus.out_par);
        end
        checks++;
        if (err_cnt !== 2'd1) begin errors++; $display("FAIL chk_cnt1 got=%0d exp=1", err_cnt); end
        send(8'h01, 1'b1);
        checks++;
        if (bus.out_err !== 1'b0) begin errors++; $display("FAIL chk_even_good got=%b exp=0", bus.out_err); end
        checks++;
        if (err_cnt !== 2'd1) begin errors++; $display("FAIL chk_cnt_hold got=%0d exp=1", err_cnt); end
    endtask

    task automatic test_mark_space;
        parity_en = 1; chk_mode = 1; char_len = 4'd8;
        par_mode = 2'b10;
        send(8'h00, 1'b0);
        checks++;
        if (bus.out_err !== 1'b1 || bus.out_par !== 1'b1) begin
            errors++; $display("FAIL mark got=%b/%b exp=err1/par1", bus.out_err, bus.out_par);
        end
        checks++;
        if (err_cnt !== 2'd2) begin errors++; $display("FAIL mark_cnt got=%0d exp=2", err_cnt); end
        par_mode = 2'b11;
        send(8'h00, 1'b0);
        checks++;
        if (bus.out_err !== 1'b0 || bus.out_par !== 1'b0) begin
            errors++; $display("FAIL space got=%b/%b exp=err0/par0", bus.out_err, bus.out_par);
        end
        parity_en = 0; par_mode = 2'b10;
        send(8'hB7, 1'b1);
        checks++;
        if (bus.out_err !== 1'b0 || bus.out_par !== 1'b0 || bus.out_data !== 8'hB7) begin
            errors++; $display("FAIL par_dis got=%b/%b/%h exp=0/0/b7", bus.out_err, bus.out_par, bus.out_data);
        end
        checks++;
        if (err_cnt !== 2'd2) begin errors++; $display("FAIL par_dis_cnt got=%0d exp=2", err_cnt); end
        parity_en = 1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [3];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        parity_en = 1; par_mode = 2'b00; chk_mode = 0; char_len = 4'd8;
        send(8'h3C, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.in_par = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_data !== 8'h3C || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=0/3c", c, bus.in_ready, bus.out_data);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_data !== 8'h5A || bus.out_par !== 1'b0) begin
            errors++; $display("FAIL bp_release got=%h/%b exp=5a/0", bus.out_data, bus.out_par);
        end
        for (int j = 0; j < 3; j++) begin
            bus.in_data = seq[j];
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== seq[j]) begin
                errors++; $display("FAIL stream beat=%0d got=%h exp=%h", j, bus.out_data, seq[j]);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        err_cnt_clr = 1'b1;
        @(posedge clk); #1;
        err_cnt_clr = 1'b0;
        checks++;
        if (err_cnt !== 2'd0) begin errors++; $display("FAIL clr_idle got=%0d exp=0", err_cnt); end
        parity_en = 1; par_mode = 2'b00; chk_mode = 1; char_len = 4'd8;
        for (int e = 0; e < 5; e++) begin
            send(8'h01, 1'b0);
            checks++;
            if (err_cnt !== exp_cnt[e]) begin errors++; $display("FAIL sat err=%0d got=%0d exp=%0d", e, err_cnt, exp_cnt[e]); end
        end
        err_cnt_clr = 1'b1;
        send(8'h01, 1'b0);
        err_cnt_clr = 1'b0;
        checks++;
        if (err_cnt !== 2'd0 || bus.out_err !== 1'b1) begin
            errors++; $display("FAIL clr_override got=%0d/%b exp=0/1", err_cnt, bus.out_err);
        end
    endtask

    task automatic test_async_reset;
        parity_en = 1; par_mode = 2'b00; chk_mode = 1; char_len = 4'd8;
        send(8'h07, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || err_cnt !== 2'd1) begin
            errors++; $display("FAIL areset_pre got=%b/%0d exp=1/1", bus.out_valid, err_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || err_cnt !== 2'd0 || bus.out_data !== 8'h00) begin
            errors++; $display("FAIL areset got=%b/%0d/%h exp=0/0/00", bus.out_valid, err_cnt, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%b exp=1", bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_even_gen();
        test_odd_len();
        test_check_mode();
        test_mark_space();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
